pipe_barrel_shifter: RTL and testbench

PIPE_BARREL_SHIFTER -- requirements
Module: pipe_barrel_shifter

---
 rtl/pipe_shift_pkg.sv | 17 +
 rtl/shift_stage.sv | 128 ++++++++++++
 rtl/pipe_barrel_shifter.sv | 79 +++++++
 tb/tb_pipe_barrel_shifter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_shift_pkg.sv
// Shared definitions for the pipelined radix-4 barrel shifter:
// operation encodings and the pipeline-depth helper.
package pipe_shift_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_SLL = 2'b00;
  localparam op_t OP_SRL = 2'b01;
  localparam op_t OP_SRA = 2'b10;
  localparam op_t OP_ROR = 2'b11;

  // Each stage retires two amount bits, so depth is ceil(log2(width)/2).
  function automatic int num_stages(input int width);
    return ($clog2(width) + 1) / 2;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One radix-4 shifter stage: shifts by d*4^STAGE_IDX (d from two amount bits)
// and registers the result together with the operation's sideband state.
module shift_stage
  import pipe_shift_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAGW      = 4,
  parameter int STAGE_IDX = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     advance,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  op_t                      in_op,
  input  logic                     in_sign,
  input  logic [TAGW-1:0]          in_tag,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(WIDTH)-1:0] out_amt,
  output op_t                      out_op,
  output logic                     out_sign,
  output logic [TAGW-1:0]          out_tag
);

  localparam int SW     = $clog2(WIDTH);
  localparam int STAGES = num_stages(WIDTH);
  localparam int STEP   = 1 << (2 * STAGE_IDX);
  localparam bit HALF   = (STAGE_IDX == STAGES - 1) && (SW % 2 == 1);

  function automatic logic [WIDTH-1:0] shift_const(
    input logic [WIDTH-1:0] data,
    input op_t              op,
    input logic             sign,
    input int               sh
  );
    logic [2*WIDTH-1:0] ext;
    logic [WIDTH-1:0]   res;
    ext = '0;
    case (op)
      OP_SLL: res = data << sh;
      OP_SRL: res = data >> sh;
      OP_SRA: begin
        ext = {{WIDTH{sign}}, data} >> sh;
        res = ext[WIDTH-1:0];
      end
      default: begin
        ext = {data, data} >> sh;
        res = ext[WIDTH-1:0];
      end
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] cand [4];
  logic [1:0]       digit;

  // Candidates whose distance reaches WIDTH are never selected; tie them off.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    localparam int SH = gi * STEP;
    if (SH < WIDTH) begin : g_on
      assign cand[gi] = shift_const(in_data, in_op, in_sign, SH);
    end else begin : g_off
      assign cand[gi] = in_data;
    end
  end

  if (HALF) begin : g_digit_half
    assign digit = {1'b0, in_amt[SW-1]};
  end else begin : g_digit_full
    assign digit = in_amt[2*STAGE_IDX +: 2];
  end

  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [SW-1:0]        amt_q, amt_d;
  op_t                  op_q, op_d;
  logic                 sign_q, sign_d;
  logic [TAGW-1:0]      tag_q, tag_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    tag_d   = tag_q;
    if (advance) begin
      valid_d = in_valid;
      data_d  = cand[digit];
      amt_d   = in_amt;
      op_d    = in_op;
      sign_d  = in_sign;
      tag_d   = in_tag;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= OP_SLL;
      sign_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_amt   = amt_q;
  assign out_op    = op_q;
  assign out_sign  = sign_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake;
// the whole pipeline advances together whenever the output slot can move.
module pipe_barrel_shifter
  import pipe_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [1:0]               in_op,
  input  logic [TAGW-1:0]          in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAGW-1:0]          out_tag
);

  localparam int SW     = $clog2(WIDTH);
  localparam int STAGES = num_stages(WIDTH);

  logic advance;

  logic             valid_c [STAGES+1];
  logic [WIDTH-1:0] data_c  [STAGES+1];
  logic [SW-1:0]    amt_c   [STAGES+1];
  op_t              op_c    [STAGES+1];
  logic             sign_c  [STAGES+1];
  logic [TAGW-1:0]  tag_c   [STAGES+1];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign valid_c[0] = in_valid;
  assign data_c[0]  = in_data;
  assign amt_c[0]   = in_amt;
  assign op_c[0]    = in_op;
  assign sign_c[0]  = in_data[WIDTH-1];
  assign tag_c[0]   = in_tag;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    shift_stage #(
      .WIDTH     (WIDTH),
      .TAGW      (TAGW),
      .STAGE_IDX (gi)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (advance),
      .flush     (flush),
      .in_valid  (valid_c[gi]),
      .in_data   (data_c[gi]),
      .in_amt    (amt_c[gi]),
      .in_op     (op_c[gi]),
      .in_sign   (sign_c[gi]),
      .in_tag    (tag_c[gi]),
      .out_valid (valid_c[gi+1]),
      .out_data  (data_c[gi+1]),
      .out_amt   (amt_c[gi+1]),
      .out_op    (op_c[gi+1]),
      .out_sign  (sign_c[gi+1]),
      .out_tag   (tag_c[gi+1])
    );
  end

  // Amount, op and sign have no consumer past the final stage.
  logic unused_tail;
  assign unused_tail = ^{amt_c[STAGES], op_c[STAGES], sign_c[STAGES]};

  assign out_valid = valid_c[STAGES];
  assign out_data  = data_c[STAGES];
  assign out_tag   = tag_c[STAGES];

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Bench for pipe_barrel_shifter: directed checks on a 32-bit instance plus
// randomized traffic on 8/16/32/64-bit instances against an arithmetic model.
module tb_pipe_barrel_shifter;
  import pipe_shift_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic [5:0]  in_amt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;

  int tests_run    = 0;
  int tests_failed = 0;

  logic        o8_valid,  o16_valid,  o32_valid,  o64_valid;
  logic        r8_ready,  r16_ready,  r32_ready,  r64_ready;
  logic [7:0]  o8_data;
  logic [15:0] o16_data;
  logic [31:0] o32_data;
  logic [63:0] o64_data;
  logic [3:0]  o8_tag,    o16_tag,    o32_tag,    o64_tag;

  pipe_barrel_shifter #(.WIDTH(8), .TAGW(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r8_ready),
    .in_data(in_data[7:0]), .in_amt(in_amt[2:0]), .in_op(in_op), .in_tag(in_tag),
    .out_valid(o8_valid), .out_ready(out_ready), .out_data(o8_data), .out_tag(o8_tag));
  pipe_barrel_shifter #(.WIDTH(16), .TAGW(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r16_ready),
    .in_data(in_data[15:0]), .in_amt(in_amt[3:0]), .in_op(in_op), .in_tag(in_tag),
    .out_valid(o16_valid), .out_ready(out_ready), .out_data(o16_data), .out_tag(o16_tag));
  pipe_barrel_shifter #(.WIDTH(32), .TAGW(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32_ready),
    .in_data(in_data[31:0]), .in_amt(in_amt[4:0]), .in_op(in_op), .in_tag(in_tag),
    .out_valid(o32_valid), .out_ready(out_ready), .out_data(o32_data), .out_tag(o32_tag));
  pipe_barrel_shifter #(.WIDTH(64), .TAGW(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64_ready),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(o64_valid), .out_ready(out_ready), .out_data(o64_data), .out_tag(o64_tag));

  logic        ov [4];
  logic        ir [4];
  logic [63:0] od [4];
  logic [3:0]  ot [4];

  assign ov[0] = o8_valid;  assign ov[1] = o16_valid; assign ov[2] = o32_valid; assign ov[3] = o64_valid;
  assign ir[0] = r8_ready;  assign ir[1] = r16_ready; assign ir[2] = r32_ready; assign ir[3] = r64_ready;
  assign od[0] = {56'd0, o8_data};
  assign od[1] = {48'd0, o16_data};
  assign od[2] = {32'd0, o32_data};
  assign od[3] = o64_data;
  assign ot[0] = o8_tag;    assign ot[1] = o16_tag;   assign ot[2] = o32_tag;   assign ot[3] = o64_tag;

  // Reference: shift defined directly on integers of width w.
  function automatic logic [63:0] ref_shift(input int w, input logic [63:0] d,
                                            input int amt, input logic [1:0] op);
    logic [63:0] mask, x, r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x = d & mask;
    case (op)
      OP_SLL: r = (x << amt) & mask;
      OP_SRL: r = x >> amt;
      OP_SRA: begin
        r = x >> amt;
        if (x[w-1]) r = r | (mask & ~(mask >> amt));
      end
      default: r = ((x >> amt) | (x << (w - amt))) & mask;
    endcase
    return r;
  endfunction

  // Presents one op to an empty pipeline and waits (bounded) for its result.
  task automatic run_op(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                        input logic [3:0] tag, output logic [31:0] res, output logic [3:0] rtag,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = {32'h0, d}; in_amt = {1'b0, a}; in_op = op; in_tag = tag;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!ov[2] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res  = od[2][31:0];
    rtag = ot[2];
    $display("[TB] op=%0d data=%h amt=%0d tag=%0d -> %h tag=%0d lat=%0d", op, d, a, tag, res, rtag, lat);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests_run += 4;
      if (ov[i] !== 1'b0) begin tests_failed++; $display("FAIL reset_valid[%0d]: got %b want 0", i, ov[i]); end
      if (od[i] !== 64'd0) begin tests_failed++; $display("FAIL reset_data[%0d]: got %h want 0", i, od[i]); end
      if (ot[i] !== 4'd0) begin tests_failed++; $display("FAIL reset_tag[%0d]: got %h want 0", i, ot[i]); end
      if (ir[i] !== 1'b1) begin tests_failed++; $display("FAIL reset_ready[%0d]: got %b want 1", i, ir[i]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sll_latency();
    logic [31:0] res; logic [3:0] rt; int lat;
    run_op(32'h0000_0001, 5'd31, OP_SLL, 4'd9, res, rt, lat);
    tests_run += 3;
    if (lat !== 3) begin tests_failed++; $display("FAIL sll_latency: got %0d want 3", lat); end
    if (res !== 32'h8000_0000) begin tests_failed++; $display("FAIL sll_data: got %h want 80000000", res); end
    if (rt !== 4'd9) begin tests_failed++; $display("FAIL sll_tag: got %0d want 9", rt); end
  endtask

  task automatic test_vectors();
    logic [31:0] vd [7]; logic [4:0] va [7]; logic [1:0] vo [7]; logic [31:0] ve [7];
    logic [31:0] res; logic [3:0] rt; int lat;
    vd = '{32'h8000_0000, 32'h8000_0000, 32'h0000_00F1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    va = '{5'd4, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
    vo = '{OP_SRA, OP_SRL, OP_ROR, OP_SLL, OP_SRL, OP_SRA, OP_ROR};
    ve = '{32'hF800_0000, 32'h0800_0000, 32'h1000_000F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      run_op(vd[i], va[i], vo[i], 4'(i), res, rt, lat);
      tests_run += 2;
      if (res !== ve[i]) begin tests_failed++; $display("FAIL vector[%0d]: got %h want %h", i, res, ve[i]); end
      if (lat !== 3) begin tests_failed++; $display("FAIL vector_latency[%0d]: got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bd [8]; logic [4:0] ba [8]; logic [1:0] bo [8];
    logic [31:0] held, exp;
    int sent, recv;
    sent = 0; recv = 0; held = '0;
    for (int i = 0; i < 8; i++) begin
      bd[i] = $urandom; ba[i] = 5'($urandom_range(0, 31)); bo[i] = 2'($urandom_range(0, 3));
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 8);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_data = {32'h0, bd[sent]}; in_amt = {1'b0, ba[sent]}; in_op = bo[sent]; in_tag = 4'(sent);
      end
      #1;
      if (cyc == 3) begin
        tests_run++;
        if (ov[2] !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_out: got %b want 1", ov[2]); end
      end
      if (cyc >= 4 && cyc <= 8) begin
        tests_run++;
        if (ir[2] !== 1'b0) begin tests_failed++; $display("FAIL b2b_stall_ready cyc %0d: got %b want 0", cyc, ir[2]); end
        if (cyc == 4) held = od[2][31:0];
        else begin
          tests_run++;
          if (od[2][31:0] !== held) begin tests_failed++; $display("FAIL b2b_hold cyc %0d: got %h want %h", cyc, od[2][31:0], held); end
        end
      end
      if (ov[2] && out_ready) begin
        tests_run++;
        if (recv >= 8) begin
          tests_failed++; $display("FAIL b2b_extra: got tag %0d want no result", ot[2]);
        end else begin
          exp = ref_shift(32, {32'h0, bd[recv]}, int'(ba[recv]), bo[recv])[31:0];
          $display("[TB] b2b out tag=%0d data=%h", ot[2], od[2][31:0]);
          if (ot[2] !== 4'(recv) || od[2][31:0] !== exp) begin
            tests_failed++;
            $display("FAIL b2b_result %0d: got tag %0d data %h want tag %0d data %h", recv, ot[2], od[2][31:0], recv, exp);
          end
        end
        recv++;
      end
      if (in_valid && ir[2]) sent++;
    end
    in_valid = 1'b0;
    tests_run += 2;
    if (sent !== 8) begin tests_failed++; $display("FAIL b2b_sent: got %0d want 8", sent); end
    if (recv !== 8) begin tests_failed++; $display("FAIL b2b_recv: got %0d want 8", recv); end
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [3:0] rt; int lat;
    out_ready = 1'b1;
    // Two ops enter the pipe, a third is presented together with flush.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = {32'h0, 32'h1111_0000 + 32'(k)}; in_amt = 6'(k + 1);
      in_op = OP_SRL; in_tag = 4'(k + 10);
      flush = (k == 2);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      tests_run++;
      if (ov[2] !== 1'b0) begin tests_failed++; $display("FAIL flush_valid cyc %0d: got %b tag %0d want 0", k, ov[2], ot[2]); end
      @(negedge clk);
    end
    run_op(32'h1234_5678, 5'd8, OP_ROR, 4'd3, res, rt, lat);
    tests_run += 3;
    if (lat !== 3) begin tests_failed++; $display("FAIL flush_next_latency: got %0d want 3", lat); end
    if (res !== 32'h7812_3456) begin tests_failed++; $display("FAIL flush_next_data: got %h want 78123456", res); end
    if (rt !== 4'd3) begin tests_failed++; $display("FAIL flush_next_tag: got %0d want 3", rt); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res; logic [3:0] rt; int lat;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = {32'h0, 32'hDEAD_BEEF}; in_amt = 6'(k); in_op = OP_ROR; in_tag = 4'(k + 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run += 3;
    if (ov[2] !== 1'b0) begin tests_failed++; $display("FAIL arst_valid: got %b want 0", ov[2]); end
    if (od[2] !== 64'd0) begin tests_failed++; $display("FAIL arst_data: got %h want 0", od[2]); end
    if (ot[2] !== 4'd0) begin tests_failed++; $display("FAIL arst_tag: got %0d want 0", ot[2]); end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'hA5A5_A5A5, 5'd1, OP_SRA, 4'd6, res, rt, lat);
    tests_run += 3;
    if (lat !== 3) begin tests_failed++; $display("FAIL arst_next_latency: got %0d want 3", lat); end
    if (res !== 32'hD2D2_D2D2) begin tests_failed++; $display("FAIL arst_next_data: got %h want d2d2d2d2", res); end
    if (rt !== 4'd6) begin tests_failed++; $display("FAIL arst_next_tag: got %0d want 6", rt); end
  endtask

  logic [63:0] sb_data [4][512];
  logic [3:0]  sb_tag  [4][512];
  int          sb_wr   [4];
  int          sb_rd   [4];

  task automatic test_random();
    int w;
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin sb_wr[i] = 0; sb_rd[i] = 0; end
    for (int cyc = 0; cyc < 620; cyc++) begin
      @(negedge clk);
      if (cyc < 600) begin
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid  = ($urandom_range(0, 4) != 0);
        in_data   = {$urandom, $urandom};
        in_amt    = 6'($urandom_range(0, 63));
        in_op     = 2'($urandom_range(0, 3));
        in_tag    = 4'(cyc);
      end else begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        w = 8 << i;
        if (ov[i] && out_ready) begin
          tests_run++;
          if (sb_rd[i] == sb_wr[i]) begin
            tests_failed++;
            $display("FAIL rand_w%0d_spurious: got data %h tag %0d want no result", w, od[i], ot[i]);
          end else begin
            $display("[TB] rand w=%0d tag=%0d data=%h", w, ot[i], od[i]);
            if (od[i] !== sb_data[i][sb_rd[i] % 512] || ot[i] !== sb_tag[i][sb_rd[i] % 512]) begin
              tests_failed++;
              $display("FAIL rand_w%0d: got data %h tag %0d want data %h tag %0d", w, od[i], ot[i],
                       sb_data[i][sb_rd[i] % 512], sb_tag[i][sb_rd[i] % 512]);
            end
            sb_rd[i]++;
          end
        end
        if (in_valid && ir[i]) begin
          sb_data[i][sb_wr[i] % 512] = ref_shift(w, in_data, int'(in_amt) & (w - 1), in_op);
          sb_tag[i][sb_wr[i] % 512]  = in_tag;
          sb_wr[i]++;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (sb_rd[i] !== sb_wr[i] || sb_wr[i] < 50) begin
        tests_failed++;
        $display("FAIL rand_w%0d_drain: got %0d results want %0d (accepted)", 8 << i, sb_rd[i], sb_wr[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_amt = '0; in_op = OP_SLL; in_tag = '0;
    test_reset();
    test_sll_latency();
    test_vectors();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
